// File: rtl/core_mmio_timer.sv
// core_mmio_timer
// Machine timer responder on the core MMIO request/grant bus.
// Holds mtime, mtimecmp and a control register (bit0 = count enable), and
// raises a level interrupt whenever mtime >= mtimecmp (unsigned).
// Every request is granted in the cycle it is presented. The read data and
// error response are registered on the grant and held until the next grant.

module core_mmio_timer #(
    parameter logic [63:0] MMIO_BASE_ADDR = 64'h1000,
    parameter int unsigned PRESCALE       = 1
) (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        mmio_req,
    input  logic        mmio_wen,
    input  logic [63:0] mmio_addr,
    input  logic [63:0] mmio_wdata,
    output logic        mmio_gnt,
    output logic [63:0] mmio_rdata,
    output logic        mmio_error,
    output logic        irq_timer
);

    // A one-bit prescaler is kept even when PRESCALE is 1, so the wrap
    // compare below stays well formed. With PRESCALE 1 it wraps every cycle.
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESCALE_LAST = PW'(PRESCALE - 1);

    logic [63:0]   mtime;
    logic [63:0]   mtimecmp;
    logic          enable;
    logic [PW-1:0] prescaler;

    logic [63:0]   mtime_next;
    logic [63:0]   mtimecmp_next;
    logic          enable_next;
    logic [PW-1:0] prescaler_next;

    logic [63:0]   offset;
    logic          sel_mtime;
    logic          sel_mtimecmp;
    logic          sel_ctrl;
    logic          addr_error;
    logic          wr_mtime;
    logic          wr_mtimecmp;
    logic          wr_ctrl;
    logic [63:0]   rd_value;

    // Decode the access. Any offset outside the three aligned registers is
    // an error, and an erroring access never writes a register.
    assign offset       = mmio_addr - MMIO_BASE_ADDR;
    assign sel_mtime    = (offset == 64'h000);
    assign sel_mtimecmp = (offset == 64'h008);
    assign sel_ctrl     = (offset == 64'h010);
    assign addr_error   = !(sel_mtime || sel_mtimecmp || sel_ctrl);

    assign wr_mtime     = mmio_req && mmio_wen && sel_mtime;
    assign wr_mtimecmp  = mmio_req && mmio_wen && sel_mtimecmp;
    assign wr_ctrl      = mmio_req && mmio_wen && sel_ctrl;

    assign mmio_gnt     = mmio_req;

    // Read mux: present the register values as they are before this cycle's update.
    always_comb begin
        rd_value = '0;
        if (sel_mtime) begin
            rd_value = mtime;
        end else if (sel_mtimecmp) begin
            rd_value = mtimecmp;
        end else if (sel_ctrl) begin
            rd_value = {63'b0, enable};
        end
    end

    // Counter update: a bus write to mtime beats an increment in the same cycle and restarts the prescaler.
    always_comb begin
        mtime_next     = mtime;
        prescaler_next = prescaler;
        if (wr_mtime) begin
            mtime_next     = mmio_wdata;
            prescaler_next = '0;
        end else if (enable) begin
            if (prescaler == PRESCALE_LAST) begin
                prescaler_next = '0;
                mtime_next     = mtime + 64'd1;
            end else begin
                prescaler_next = prescaler + PW'(1);
            end
        end
    end

    // Next values of the compare and control registers.
    always_comb begin
        mtimecmp_next = wr_mtimecmp ? mmio_wdata : mtimecmp;
        enable_next   = wr_ctrl ? mmio_wdata[0] : enable;
    end

    // Timer state and interrupt. The interrupt is taken from the next-state values so it tracks a write one cycle after the grant.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            mtime     <= '0;
            mtimecmp  <= '1;
            enable    <= 1'b1;
            prescaler <= '0;
            irq_timer <= 1'b0;
        end else begin
            mtime     <= mtime_next;
            mtimecmp  <= mtimecmp_next;
            enable    <= enable_next;
            prescaler <= prescaler_next;
            irq_timer <= (mtime_next >= mtimecmp_next);
        end
    end

    // Response registers: loaded on every grant and held until the next one. Writes and errors return zero data.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            mmio_rdata <= '0;
            mmio_error <= 1'b0;
        end else if (mmio_req) begin
            mmio_rdata <= (!mmio_wen && !addr_error) ? rd_value : 64'd0;
            mmio_error <= addr_error;
        end
    end

endmodule

// File: tb/tb_core_mmio_timer.sv
// tb_core_mmio_timer
// Two timers (PRESCALE 1 and 4) receive the same bus traffic. Each one is
// compared against a reference model. The model holds mtime as a base value
// plus a count of enabled cycles since the last mtime write or reset. The
// value for each instance is then base + cycles / PRESCALE.

module tb_core_mmio_timer;

    localparam logic [63:0] BASE = 64'h1000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        g_clk = 1'b0;
    logic        g_reset;
    logic        mmio_req;
    logic        mmio_wen;
    logic [63:0] mmio_addr;
    logic [63:0] mmio_wdata;

    logic        gnt1, err1, irq1;
    logic [63:0] rdata1;
    logic        gnt4, err4, irq4;
    logic [63:0] rdata4;

    int check_count = 0;
    int error_count = 0;

    logic [63:0] m_base, m_cycles, m_cmp;
    logic        m_en;
    logic [63:0] exp_rd1, exp_rd4;
    logic        exp_err, exp_irq1, exp_irq4;

    core_mmio_timer #(.MMIO_BASE_ADDR(BASE), .PRESCALE(1)) dut1 (
        .g_clk(g_clk), .g_reset(g_reset),
        .mmio_req(mmio_req), .mmio_wen(mmio_wen),
        .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata),
        .mmio_gnt(gnt1), .mmio_rdata(rdata1),
        .mmio_error(err1), .irq_timer(irq1)
    );

    core_mmio_timer #(.MMIO_BASE_ADDR(BASE), .PRESCALE(4)) dut4 (
        .g_clk(g_clk), .g_reset(g_reset),
        .mmio_req(mmio_req), .mmio_wen(mmio_wen),
        .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata),
        .mmio_gnt(gnt4), .mmio_rdata(rdata4),
        .mmio_error(err4), .irq_timer(irq4)
    );

    always #5 g_clk = ~g_clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_count++;
        if (obs !== exp) begin
            error_count++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_base   = 64'd0;
        m_cycles = 64'd0;
        m_cmp    = ONES;
        m_en     = 1'b1;
        exp_rd1  = 64'd0;
        exp_rd4  = 64'd0;
        exp_err  = 1'b0;
        exp_irq1 = 1'b0;
        exp_irq4 = 1'b0;
    endtask

    function automatic logic [63:0] mtime1();
        return m_base + m_cycles;
    endfunction

    function automatic logic [63:0] mtime4();
        return m_base + m_cycles / 64'd4;
    endfunction

    // Apply one clock edge to the model, using the bus inputs that are currently driven.
    task automatic modelStep();
        logic [63:0] off;
        logic        bad;
        logic        old_en;
        logic        mtime_written;
        off = mmio_addr - BASE;
        bad = !(off == 64'h0 || off == 64'h8 || off == 64'h10);
        old_en = m_en;
        mtime_written = 1'b0;
        if (mmio_req) begin
            exp_err = bad;
            exp_rd1 = 64'd0;
            exp_rd4 = 64'd0;
            if (!mmio_wen && !bad) begin
                if (off == 64'h0) begin
                    exp_rd1 = mtime1();
                    exp_rd4 = mtime4();
                end else if (off == 64'h8) begin
                    exp_rd1 = m_cmp;
                    exp_rd4 = m_cmp;
                end else begin
                    exp_rd1 = {63'd0, m_en};
                    exp_rd4 = {63'd0, m_en};
                end
            end
            if (mmio_wen && !bad) begin
                if (off == 64'h0) begin
                    m_base = mmio_wdata;
                    m_cycles = 64'd0;
                    mtime_written = 1'b1;
                end else if (off == 64'h8) begin
                    m_cmp = mmio_wdata;
                end else begin
                    m_en = mmio_wdata[0];
                end
            end
        end
        if (!mtime_written && old_en) m_cycles = m_cycles + 64'd1;
        exp_irq1 = (mtime1() >= m_cmp);
        exp_irq4 = (mtime4() >= m_cmp);
    endtask

    // Called at a negedge. It drives one bus cycle, checks the combinational
    // grant, steps the model at the posedge, checks the registered outputs,
    // and returns at the next negedge.
    task automatic applyStimulus(input logic req, input logic wen, input logic [63:0] offset,
                                 input logic [63:0] wdata);
        mmio_req   = req;
        mmio_wen   = wen;
        mmio_addr  = BASE + offset;
        mmio_wdata = wdata;
        #1;
        checkOutput("gnt_p1", {63'd0, gnt1}, {63'd0, req});
        checkOutput("gnt_p4", {63'd0, gnt4}, {63'd0, req});
        @(posedge g_clk);
        modelStep();
        #1;
        checkOutput("rdata_p1", rdata1, exp_rd1);
        checkOutput("rdata_p4", rdata4, exp_rd4);
        checkOutput("error_p1", {63'd0, err1}, {63'd0, exp_err});
        checkOutput("error_p4", {63'd0, err4}, {63'd0, exp_err});
        checkOutput("irq_p1", {63'd0, irq1}, {63'd0, exp_irq1});
        checkOutput("irq_p4", {63'd0, irq4}, {63'd0, exp_irq4});
        @(negedge g_clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 64'h0, 64'h0);
    endtask

    // Watchdog: if the run overruns its time limit, report a failure and stop.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] simulation overran its time limit");
    end

    initial begin
        logic saw_irq;
        int   sel;
        logic [63:0] off;

        g_reset    = 1'b1;
        mmio_req   = 1'b0;
        mmio_wen   = 1'b0;
        mmio_addr  = BASE;
        mmio_wdata = 64'd0;
        modelReset();
        repeat (3) @(posedge g_clk);
        @(negedge g_clk);
        checkOutput("reset_rdata", rdata1, 64'd0);
        checkOutput("reset_error", {63'd0, err1}, 64'd0);
        checkOutput("reset_irq", {63'd0, irq1}, 64'd0);
        g_reset = 1'b0;

        $display("[TB] three back-to-back mtime reads after reset");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 64'h0, 64'h0);
            checkOutput("first_reads", rdata1, 64'(i));
        end

        $display("[TB] compare match at mtimecmp=5");
        applyStimulus(1'b1, 1'b1, 64'h8, 64'd5);
        saw_irq = 1'b0;
        for (int i = 0; i < 20 && !saw_irq; i++) begin
            applyStimulus(1'b1, 1'b0, 64'h0, 64'h0);
            if (irq1) saw_irq = 1'b1;
        end
        checkOutput("irq_rise_seen", {63'd0, saw_irq}, 64'd1);
        applyStimulus(1'b1, 1'b1, 64'h8, ONES);
        checkOutput("irq_fall", {63'd0, irq1}, 64'd0);
        idle(3);

        $display("[TB] mtime wrap past all ones");
        applyStimulus(1'b1, 1'b1, 64'h0, ONES);
        applyStimulus(1'b1, 1'b0, 64'h0, 64'h0);
        applyStimulus(1'b1, 1'b0, 64'h0, 64'h0);
        applyStimulus(1'b1, 1'b1, 64'h8, 64'd3);
        idle(6);

        $display("[TB] illegal offsets");
        applyStimulus(1'b1, 1'b0, 64'h18, 64'h0);
        checkOutput("err_0x18", {63'd0, err1}, 64'd1);
        applyStimulus(1'b1, 1'b0, 64'h4, 64'h0);
        checkOutput("err_0x04", {63'd0, err1}, 64'd1);
        applyStimulus(1'b1, 1'b1, 64'h20, 64'h1234);
        checkOutput("err_0x20", {63'd0, err1}, 64'd1);
        applyStimulus(1'b1, 1'b1, 64'h9, 64'h0);
        applyStimulus(1'b1, 1'b0, 64'h8, 64'h0);
        applyStimulus(1'b1, 1'b0, 64'h10, 64'h0);

        $display("[TB] counting disabled then re-enabled");
        applyStimulus(1'b1, 1'b1, 64'h10, 64'h0);
        idle(10);
        applyStimulus(1'b1, 1'b0, 64'h0, 64'h0);
        applyStimulus(1'b1, 1'b0, 64'h10, 64'h0);
        applyStimulus(1'b1, 1'b1, 64'h10, 64'hFFFF_0001);
        idle(9);
        applyStimulus(1'b1, 1'b0, 64'h0, 64'h0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 300; i++) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                0, 1, 2: applyStimulus(1'b1, 1'b0, 64'(8 * sel), 64'h0);
                3: applyStimulus(1'b1, 1'b1, 64'h0,
                                 ($urandom_range(0, 1) == 1) ? ONES - 64'($urandom_range(0, 12))
                                                            : 64'($urandom_range(0, 100)));
                4: applyStimulus(1'b1, 1'b1, 64'h8, mtime1() + 64'($urandom_range(0, 20)));
                5: applyStimulus(1'b1, 1'b1, 64'h10, {$urandom, 31'd0, ($urandom_range(0, 3) != 0)});
                6, 7: begin
                    case ($urandom_range(0, 4))
                        0: off = 64'h18;
                        1: off = 64'h4;
                        2: off = 64'h20;
                        3: off = 64'h11;
                        default: off = {$urandom, $urandom};
                    endcase
                    applyStimulus(1'b1, (sel == 7), off, {$urandom, $urandom});
                end
                default: applyStimulus(1'b0, 1'b0, 64'h0, 64'h0);
            endcase
        end

        $display("[TB] asynchronous reset after a read grant");
        applyStimulus(1'b1, 1'b1, 64'h8, 64'd0);
        applyStimulus(1'b1, 1'b1, 64'h10, 64'd1);
        applyStimulus(1'b1, 1'b1, 64'h0, 64'd77);
        applyStimulus(1'b1, 1'b0, 64'h0, 64'h0);
        checkOutput("pre_reset_rdata", rdata1, 64'd77);
        checkOutput("pre_reset_irq", {63'd0, irq1}, 64'd1);
        mmio_req = 1'b0;
        #2;
        g_reset = 1'b1;
        #1;
        checkOutput("async_rdata", rdata1, 64'd0);
        checkOutput("async_rdata_p4", rdata4, 64'd0);
        checkOutput("async_error", {63'd0, err1}, 64'd0);
        checkOutput("async_irq", {63'd0, irq1}, 64'd0);
        checkOutput("async_irq_p4", {63'd0, irq4}, 64'd0);
        modelReset();
        @(posedge g_clk);
        @(negedge g_clk);
        g_reset = 1'b0;
        applyStimulus(1'b1, 1'b0, 64'h0, 64'h0);
        checkOutput("post_reset_mtime", rdata1, 64'd0);
        applyStimulus(1'b1, 1'b0, 64'h8, 64'h0);
        checkOutput("post_reset_cmp", rdata1, ONES);
        applyStimulus(1'b1, 1'b0, 64'h10, 64'h0);
        checkOutput("post_reset_ctrl", rdata1, 64'd1);
        idle(2);

        $display("[TB] Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
